operand_input_stage: RTL and testbench

//   Upstream input stage for the four-bit seven-segment adder. Synchronises and

---
 rtl/operand_input_stage.sv | 152 +++++++++++++++
 tb/tb_operand_input_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/operand_input_stage.sv
// operand_input_stage: synchronises and debounces the two operand switch banks
// and the load/clear push-buttons, then latches the debounced operands into
// registered outputs only on a load press.
//   clk        in   1      system clock
//   rst        in   1      asynchronous, active-high reset
//   sw_a       in   WIDTH  raw switch bank, operand A
//   sw_b       in   WIDTH  raw switch bank, operand B
//   btn_load   in   1      raw push-button, latch operands
//   btn_clear  in   1      raw push-button, clear operands
//   a_out      out  WIDTH  latched operand A
//   b_out      out  WIDTH  latched operand B
//   load_pulse out  1      one-cycle strobe when a_out/b_out take loaded values
//   pending    out  1      debounced switches differ from latched operands (combinational)

// Two-flop synchroniser followed by a restartable stability counter.
module operand_debounce #(
    parameter int unsigned W               = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] raw,
    output logic [W-1:0] db
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [W-1:0]     sync1;
    logic [W-1:0]     sync2;
    logic [CNT_W-1:0] cnt;

    // Any return to equality clears the count, so a bounce restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                db  <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
endmodule

module operand_input_stage #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_a,
    input  logic [WIDTH-1:0] sw_b,
    input  logic             btn_load,
    input  logic             btn_clear,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             load_pulse,
    output logic             pending
);
    localparam int unsigned SW_W = 2 * WIDTH;

    typedef enum logic [0:0] {IDLE, WAIT_REL} state_t;

    state_t            state, state_d;
    logic [SW_W-1:0]   db_sw;
    logic              db_load, db_clear;
    logic              load_q, clear_q;
    logic              load_rise_c, clear_rise_c;
    logic [WIDTH-1:0]  a_d, b_d;
    logic              load_pulse_d;

    // Switch vector debounces as one group: any bit change restarts its count.
    operand_debounce #(.W(SW_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_sw (
        .clk(clk), .rst(rst), .raw({sw_b, sw_a}), .db(db_sw)
    );

    operand_debounce #(.W(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_load (
        .clk(clk), .rst(rst), .raw(btn_load), .db(db_load)
    );

    operand_debounce #(.W(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_clear (
        .clk(clk), .rst(rst), .raw(btn_clear), .db(db_clear)
    );

    // Delayed copies of the debounced buttons for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_q  <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            load_q  <= db_load;
            clear_q <= db_clear;
        end
    end

    assign load_rise_c  = db_load  & ~load_q;
    assign clear_rise_c = db_clear & ~clear_q;

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            a_out      <= '0;
            b_out      <= '0;
            load_pulse <= 1'b0;
        end else begin
            state      <= state_d;
            a_out      <= a_d;
            b_out      <= b_d;
            load_pulse <= load_pulse_d;
        end
    end

    // Next state and next outputs; clear overrides a simultaneous load.
    always_comb begin
        state_d      = state;
        a_d          = a_out;
        b_d          = b_out;
        load_pulse_d = 1'b0;
        case (state)
            IDLE: begin
                if (load_rise_c) begin
                    a_d          = db_sw[WIDTH-1:0];
                    b_d          = db_sw[SW_W-1:WIDTH];
                    load_pulse_d = 1'b1;
                    state_d      = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (!db_load) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (clear_rise_c) begin
            a_d          = '0;
            b_d          = '0;
            load_pulse_d = 1'b0;
        end
    end

    assign pending = (db_sw != {b_out, a_out});
endmodule

// File: tb/tb_operand_input_stage.sv
module tb_operand_input_stage;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sw_a, sw_b;
    logic       btn_load, btn_clear;
    logic [3:0] a_out, b_out;
    logic       load_pulse, pending;

    int total = 0;
    int bad   = 0;

    operand_input_stage #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .sw_a(sw_a), .sw_b(sw_b),
        .btn_load(btn_load), .btn_clear(btn_clear),
        .a_out(a_out), .b_out(b_out), .load_pulse(load_pulse), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; sw_a = 4'h0; sw_b = 4'h0; btn_load = 1'b0; btn_clear = 1'b0;
        repeat (3) tick();
        total++;
        if (a_out !== 4'h0 || b_out !== 4'h0 || load_pulse !== 1'b0 || pending !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold got a=%h b=%h lp=%b pend=%b exp 0 0 0 0", a_out, b_out, load_pulse, pending);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if (a_out !== 4'h0 || b_out !== 4'h0 || load_pulse !== 1'b0 || pending !== 1'b0) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d got a=%h b=%h lp=%b pend=%b exp 0 0 0 0", i, a_out, b_out, load_pulse, pending);
            end
        end
    endtask

    task automatic test_load();
        sw_a = 4'h9; sw_b = 4'h6;
        repeat (10) tick();
        total++;
        if (pending !== 1'b1) begin
            bad++; $display("FAIL load_pend_pre got=%b exp=1", pending);
        end
        btn_load = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            total++;
            if (load_pulse !== (k == 7)) begin
                bad++; $display("FAIL load_lp k=%0d got=%b exp=%b", k, load_pulse, (k == 7));
            end
            if (k == 6) begin
                total++;
                if (a_out !== 4'h0 || pending !== 1'b1) begin
                    bad++; $display("FAIL load_pre got a=%h pend=%b exp a=0 pend=1", a_out, pending);
                end
            end
            if (k == 7) begin
                total++;
                if (a_out !== 4'h9 || b_out !== 4'h6 || pending !== 1'b0) begin
                    bad++; $display("FAIL load_val got a=%h b=%h pend=%b exp a=9 b=6 pend=0", a_out, b_out, pending);
                end
            end
            if (k == 10) btn_load = 1'b0;
        end
        repeat (15) tick();
    endtask

    task automatic test_bounce();
        sw_a = 4'h3;
        repeat (10) tick();
        for (int k = 0; k < 12; k++) begin
            btn_load = ((k % 4) < 2);
            tick();
            total++;
            if (load_pulse !== 1'b0) begin
                bad++; $display("FAIL bounce_lp k=%0d got=%b exp=0", k, load_pulse);
            end
        end
        btn_load = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            total++;
            if (load_pulse !== 1'b0) begin
                bad++; $display("FAIL bounce_tail k=%0d got=%b exp=0", k, load_pulse);
            end
        end
        total++;
        if (a_out !== 4'h9 || b_out !== 4'h6 || pending !== 1'b1) begin
            bad++; $display("FAIL bounce_keep got a=%h b=%h pend=%b exp a=9 b=6 pend=1", a_out, b_out, pending);
        end
    endtask

    task automatic test_hold();
        int pulses;
        sw_b = 4'hC;
        repeat (10) tick();
        btn_load = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (load_pulse === 1'b1) pulses++;
            if (k == 7) begin
                total++;
                if (load_pulse !== 1'b1 || a_out !== 4'h3 || b_out !== 4'hC) begin
                    bad++; $display("FAIL hold_first got lp=%b a=%h b=%h exp lp=1 a=3 b=c", load_pulse, a_out, b_out);
                end
            end
            if (k == 50) btn_load = 1'b0;
        end
        total++;
        if (pulses !== 1) begin
            bad++; $display("FAIL hold_count got=%0d exp=1", pulses);
        end
        sw_a = 4'h5;
        repeat (10) tick();
        btn_load = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (load_pulse === 1'b1) pulses++;
            if (k == 7) begin
                total++;
                if (load_pulse !== 1'b1 || a_out !== 4'h5 || b_out !== 4'hC) begin
                    bad++; $display("FAIL hold_second got lp=%b a=%h b=%h exp lp=1 a=5 b=c", load_pulse, a_out, b_out);
                end
            end
            if (k == 10) btn_load = 1'b0;
        end
        total++;
        if (pulses !== 1) begin
            bad++; $display("FAIL hold_count2 got=%0d exp=1", pulses);
        end
        repeat (15) tick();
    endtask

    task automatic test_clear_load();
        sw_a = 4'hF;
        repeat (10) tick();
        btn_load = 1'b1; btn_clear = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            total++;
            if (load_pulse !== 1'b0) begin
                bad++; $display("FAIL clr_lp k=%0d got=%b exp=0", k, load_pulse);
            end
            if (k == 6) begin
                total++;
                if (a_out !== 4'h5 || b_out !== 4'hC) begin
                    bad++; $display("FAIL clr_pre got a=%h b=%h exp a=5 b=c", a_out, b_out);
                end
            end
            if (k == 7 || k == 20) begin
                total++;
                if (a_out !== 4'h0 || b_out !== 4'h0 || pending !== 1'b1) begin
                    bad++; $display("FAIL clr_val k=%0d got a=%h b=%h pend=%b exp a=0 b=0 pend=1", k, a_out, b_out, pending);
                end
            end
            if (k == 10) begin
                btn_load = 1'b0; btn_clear = 1'b0;
            end
        end
        repeat (15) tick();
    endtask

    task automatic test_reset_mid();
        btn_load = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        repeat (2) tick();
        total++;
        if (a_out !== 4'h0 || b_out !== 4'h0 || load_pulse !== 1'b0 || pending !== 1'b0) begin
            bad++; $display("FAIL rstmid_hold got a=%h b=%h lp=%b pend=%b exp 0 0 0 0", a_out, b_out, load_pulse, pending);
        end
        rst = 1'b0;
        repeat (2) tick();
        btn_load = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            total++;
            if (load_pulse !== 1'b0 || a_out !== 4'h0) begin
                bad++; $display("FAIL rstmid_lp k=%0d got lp=%b a=%h exp lp=0 a=0", k, load_pulse, a_out);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_bounce();
        test_hold();
        test_clear_load();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
